serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder: the additive counterpart to the team's half_subtractor.
//  - Latches two WIDTH-bit operands on a start request.
//  - Adds them LSB-first, one bit per clock, through a single full-add cell and a carry flop.
//  - Presents sum and carry-out with a one-cycle done pulse.
//  - Used where area matters more than latency, e.g. accumulators in slow control paths.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range >= 1
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      reset, synchronous, active-high
//  start      in   1      request; sampled only in IDLE
//  a          in   WIDTH  operand A; captured on accepted start
//  b          in   WIDTH  operand B; captured on accepted start
//  busy       out  1      high in RUN and DONE
//  done       out  1      one-cycle pulse; sum/carry_out valid in that cycle
//  sum        out  WIDTH  result; holds last value until next done
//  carry_out  out  1      final carry (borrow in SUB mode); holds like sum
//  sub        in   1      only when SUB_MODE_EN is defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, sum=0, carry_out=0, internal regs=0.
//  - Reset mid-operation aborts immediately. No done is produced for the aborted op.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: start=1 -> capture a,b into shift regs, carry flop=0, bit count=0, go RUN.
//    - RUN, each cycle:
//      - s = A[0]^B[0]^c; shift s into the result reg from the MSB end.
//      - c <= A[0]&B[0] | c&(A[0]^B[0]); shift A,B right by 1; count++.
//      - When count == WIDTH-1 this cycle -> go DONE.
//    - DONE, one cycle:
//      - done=1; sum/carry_out registers updated at DONE entry from the result reg and carry flop.
//      - Then go IDLE.
//  - Latency: start accepted at edge T -> done high in cycle T+WIDTH+1, i.e. RUN for WIDTH cycles then DONE.
//  - Throughput: one op per WIDTH+2 cycles. The next start is accepted the cycle after done (IDLE).
//  - start while busy (RUN or DONE) is ignored, not queued.
//  - a/b changes after capture have no effect on the op in flight.
//  - sum/carry_out change only at DONE entry and reset. Intermediate shifting is not visible on sum.
//  - Arithmetic: {carry_out,sum} = a + b, modulo 2^(WIDTH+1). No overflow flag.
//  - WIDTH=1: RUN lasts one cycle; done at T+2.
// CONFIGURATION
//  SUB_MODE_EN defined:
//  - Adds input port sub (1 bit), captured with the operands on an accepted start.
//  - sub=1:
//    - B is bit-inverted at capture; the carry flop initialises to 1.
//    - sum = a - b mod 2^WIDTH.
//    - carry_out = borrow = ~final carry, i.e. 1 iff a < b unsigned.
//  - sub=0: identical to plain add.
//  SUB_MODE_EN undefined:
//  - No sub port; add only; carry flop always initialises to 0.
// TESTING
//  1. WIDTH=8: a=0x5A, b=0x33, start one cycle
//     -> done exactly 9 cycles later; sum=0x8D, carry_out=0; busy high for those 9 cycles.
//  2. a=0xFF, b=0x01 -> sum=0x00, carry_out=1.
//     Then a=0x00, b=0x00 -> sum=0x00, carry_out=0.
//  3. a=0x01, b=0x02 started; start re-pulsed with a=0xF0, b=0x0F in RUN cycle 3
//     -> single done with sum=0x03; no second done.
//  4. a=0x80, b=0x80 started; rst high in RUN cycle 4
//     -> next cycle busy=0, sum=0, carry_out=0; no done.
//     A new start then completes normally.
//  5. SUB_MODE_EN: sub=1, a=0x10, b=0x20 -> sum=0xF0, carry_out=1.
//     sub=1, a=0x20, b=0x10 -> sum=0x10, carry_out=0.
//  6. Back-to-back: start held high continuously with a=0x01, b=0x01
//     -> done every 10 cycles (WIDTH+2), each with sum=0x02, carry_out=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for serial_adder; sub exists only with SUB_MODE_EN
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
`ifdef SUB_MODE_EN
    output sub,
`endif
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_MODE_EN
    input  sub,
`endif
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first; SUB_MODE_EN adds a subtract mode
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
`ifdef SUB_MODE_EN
  logic             sub_q, sub_d;
`endif

  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] a_shift;

  // Single full-add cell working on the current LSBs and the carry flop
  assign s      = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // The A register doubles as the result register: each sum bit enters at
  // the MSB as the consumed A bit leaves at the LSB, so after WIDTH shifts
  // it holds the complete sum.
  if (WIDTH == 1) begin : g_shift_w1
    assign a_shift = s;
  end else begin : g_shift_wn
    assign a_shift = {s, a_q[WIDTH-1:1]};
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef SUB_MODE_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
`ifdef SUB_MODE_EN
      sub_q       <= sub_d;
`endif
    end
  end

  // Next-state, operand capture, bit-step and result latch
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    count_d     = count_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
`ifdef SUB_MODE_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          count_d = '0;
          state_d = S_RUN;
`ifdef SUB_MODE_EN
          // a - b computed as a + ~b + 1
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          sub_d   = bus.sub;
`else
          b_d     = bus.b;
          c_d     = 1'b0;
`endif
        end
      end
      S_RUN: begin
        a_d     = a_shift;
        b_d     = b_q >> 1;
        c_d     = c_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d     = S_DONE;
          sum_d       = a_shift;
`ifdef SUB_MODE_EN
          // In subtract mode the reported bit is the borrow, i.e. ~carry
          carry_out_d = c_next ^ sub_q;
`else
          carry_out_d = c_next;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (SUB_MODE_EN optional)
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; checks latency, busy span, result, hold and return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_co, input string name);
    int  lat;
    bit  busy_ok;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 50) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    check({name, " latency"}, lat, W + 1);
    check({name, " busy"}, {31'd0, busy_ok & bus.busy}, 32'd1);
    check({name, " sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
    check({name, " carry"}, {31'd0, bus.carry_out}, {31'd0, exp_co});
    step();
    check({name, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({name, " hold"}, {23'd0, bus.carry_out, bus.sum}, {23'd0, exp_co, exp_sum});
  endtask

  initial begin
    int lat;
    int ndone;
    int first_done;
    int done_cyc [3];

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[7] = '{8'h9C, 8'hA7, 8'h43, 1'b1};
    vecs[8] = '{8'hC3, 8'h3C, 8'hFF, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SUB_MODE_EN
    bus.sub   = 1'b0;
`endif
    step();
    step();
    check("reset outputs", {22'd0, bus.busy, bus.done, bus.carry_out, bus.sum}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].co, $sformatf("vec%0d", i));
    end

`ifdef SUB_MODE_EN
    bus.sub = 1'b1;
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, "sub 10-20");
    run_op(8'h20, 8'h10, 8'h10, 1'b0, "sub 20-10");
    run_op(8'h55, 8'h55, 8'h00, 1'b0, "sub 55-55");
    bus.sub = 1'b0;
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "sub0 add");
`endif

    // start re-pulsed in RUN cycle 3 must be ignored
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 4;
    while (!bus.done && lat < 50) begin
      step();
      lat++;
    end
    check("ignore start latency", lat, W + 1);
    check("ignore start sum", {23'd0, bus.carry_out, bus.sum}, 32'h003);
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (bus.done) ndone++;
    end
    check("ignore start no second done", ndone, 0);

    // reset in RUN cycle 4 aborts with no done
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort outputs", {22'd0, bus.busy, bus.done, bus.carry_out, bus.sum}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (bus.done) ndone++;
    end
    check("abort no done", ndone, 0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, "after abort");

    // start held high: one done every W+2 cycles
    bus.a      = 8'h01;
    bus.b      = 8'h01;
    bus.start  = 1'b1;
    ndone      = 0;
    first_done = 0;
    for (int cyc = 1; cyc <= 60 && ndone < 3; cyc++) begin
      step();
      if (bus.done) begin
        done_cyc[ndone] = cyc;
        if (bus.sum !== 8'h02 || bus.carry_out !== 1'b0) first_done++;
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("b2b done count", ndone, 3);
    check("b2b results", first_done, 0);
    if (ndone == 3) begin
      check("b2b first done", done_cyc[0], W + 1);
      check("b2b period 1", done_cyc[1] - done_cyc[0], W + 2);
      check("b2b period 2", done_cyc[2] - done_cyc[1], W + 2);
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
